// File: rtl/control_if.sv
// control_if: strobe/status bundle between the multiplier
// control FSM and the shift-add datapath.
//
// Signals:
//   St    start request          (datapath side -> control)
//   M     multiplier LSB         (datapath side -> control)
//   K     counter terminal flag  (datapath side -> control)
//   Idle  FSM sits in S0         (control -> datapath side)
//   Load  load operands, clear   (control -> datapath side)
//   Ad    add multiplicand       (control -> datapath side)
//   Sh    shift and count        (control -> datapath side)
//   Done  product complete       (control -> datapath side)
//
// Modports:
//   master  the control FSM
//   slave   the datapath / environment

interface control_if;
  logic St;
  logic M;
  logic K;
  logic Idle;
  logic Load;
  logic Ad;
  logic Sh;
  logic Done;

  modport master (
    input  St,
    input  M,
    input  K,
    output Idle,
    output Load,
    output Ad,
    output Sh,
    output Done
  );

  modport slave (
    output St,
    output M,
    output K,
    input  Idle,
    input  Load,
    input  Ad,
    input  Sh,
    input  Done
  );
endinterface

// File: rtl/control.sv
// control: four-state Mealy FSM sequencing a shift-add
// multiplier (load, add/shift per bit, done).
//
// Ports:
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset, forces S0
//   bus    control_if.master (St, M, K in;
//          Idle, Load, Ad, Sh, Done out)
//   State  2-bit registered state, only when
//          CONTROL_STATE_OUT_EN is defined
//
// States: S0=00 idle, S1=01 decide, S2=10 shift after
// add, S3=11 done. All outputs are Mealy combinational.

module control (
  input  logic     Clk,
  input  logic     Rst_n,
`ifdef CONTROL_STATE_OUT_EN
  control_if.master bus,
  output logic [1:0] State
`else
  control_if.master bus
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;

  logic idle_c;
  logic load_c;
  logic ad_c;
  logic sh_c;
  logic done_c;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idle_c    = 1'b0;
    load_c    = 1'b0;
    ad_c      = 1'b0;
    sh_c      = 1'b0;
    done_c    = 1'b0;
    case (state)
      S0: begin
        idle_c = 1'b1;
        if (bus.St) begin
          load_c    = 1'b1;
          state_nxt = S1;
        end
      end
      S1: begin
        if (bus.M) begin
          ad_c      = 1'b1;
          state_nxt = S2;
        end else begin
          sh_c      = 1'b1;
          state_nxt = bus.K ? S3 : S1;
        end
      end
      S2: begin
        sh_c      = 1'b1;
        state_nxt = bus.K ? S3 : S1;
      end
      S3: begin
        done_c    = 1'b1;
        state_nxt = S0;
      end
      default: begin
        state_nxt = S0;
      end
    endcase
  end

  // The register already holds S0 during reset, so only
  // Load (which depends on St) needs explicit gating.
  assign bus.Idle = idle_c;
  assign bus.Load = load_c & Rst_n;
  assign bus.Ad   = ad_c;
  assign bus.Sh   = sh_c;
  assign bus.Done = done_c;

`ifdef CONTROL_STATE_OUT_EN
  assign State = state;
`endif

  a_ad_sh_excl : assert property (
    @(posedge Clk) disable iff (!Rst_n)
    !(bus.Ad && bus.Sh)
  );

  a_load_idle : assert property (
    @(posedge Clk) disable iff (!Rst_n)
    bus.Load |-> bus.Idle
  );

endmodule

// File: tb/tb_control.sv
// tb_control: directed self-checking bench for the
// multiplier control FSM.

module tb_control;

  logic Clk;
  logic Rst_n;
`ifdef CONTROL_STATE_OUT_EN
  logic [1:0] State;
`endif

  int checks;
  int errors;

  control_if bus ();

  control u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
`ifdef CONTROL_STATE_OUT_EN
    .bus   (bus.master),
    .State (State)
`else
    .bus   (bus.master)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // {Idle, Load, Ad, Sh, Done}
  function automatic logic [4:0] outs();
    return {bus.Idle, bus.Load, bus.Ad, bus.Sh, bus.Done};
  endfunction

  // Drive inputs on the falling edge, settle 1 time unit.
  task automatic drive(input logic st, input logic m,
                       input logic k);
    @(negedge Clk);
    bus.St = st;
    bus.M  = m;
    bus.K  = k;
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_hold got %b want %b",
               outs(), 5'b10000);
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_hold_edge got %b want %b",
               outs(), 5'b10000);
    end
`ifdef CONTROL_STATE_OUT_EN
    checks++;
    if (State !== 2'b00) begin
      errors++;
      $display("FAIL reset_state got %b want %b",
               State, 2'b00);
    end
`endif
    Rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== 5'b11000) begin
      errors++;
      $display("FAIL reset_release got %b want %b",
               outs(), 5'b11000);
    end
  endtask

  task automatic test_start();
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b11000) begin
      errors++;
      $display("FAIL start_load got %b want %b",
               outs(), 5'b11000);
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs() !== 5'b00100) begin
      errors++;
      $display("FAIL start_s1_add got %b want %b",
               outs(), 5'b00100);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b00010) begin
      errors++;
      $display("FAIL start_s2_sh got %b want %b",
               outs(), 5'b00010);
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (outs() !== 5'b00010) begin
      errors++;
      $display("FAIL start_s1_last got %b want %b",
               outs(), 5'b00010);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b00001) begin
      errors++;
      $display("FAIL start_done got %b want %b",
               outs(), 5'b00001);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL start_idle got %b want %b",
               outs(), 5'b10000);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b11000) begin
      errors++;
      $display("FAIL zero_load got %b want %b",
               outs(), 5'b11000);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, (i == 3));
      checks++;
      if (outs() !== 5'b00010) begin
        errors++;
        $display("FAIL zero_shift%0d got %b want %b",
                 i, outs(), 5'b00010);
      end
    end
    // St high in S3 must be ignored.
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b00001) begin
      errors++;
      $display("FAIL zero_done got %b want %b",
               outs(), 5'b00001);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL zero_idle got %b want %b",
               outs(), 5'b10000);
    end
  endtask

  task automatic test_all_one();
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (outs() !== 5'b11000) begin
      errors++;
      $display("FAIL one_load got %b want %b",
               outs(), 5'b11000);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (outs() !== 5'b00100) begin
        errors++;
        $display("FAIL one_add%0d got %b want %b",
                 i, outs(), 5'b00100);
      end
      drive(1'b0, 1'b1, (i == 3));
      checks++;
      if (outs() !== 5'b00010) begin
        errors++;
        $display("FAIL one_shift%0d got %b want %b",
                 i, outs(), 5'b00010);
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs() !== 5'b00001) begin
      errors++;
      $display("FAIL one_done got %b want %b",
               outs(), 5'b00001);
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL one_done_once got %b want %b",
               outs(), 5'b10000);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs() !== 5'b00010) begin
      errors++;
      $display("FAIL areset_in_s2 got %b want %b",
               outs(), 5'b00010);
    end
`ifdef CONTROL_STATE_OUT_EN
    checks++;
    if (State !== 2'b10) begin
      errors++;
      $display("FAIL areset_state_s2 got %b want %b",
               State, 2'b10);
    end
`endif
    // No clock edge between here and the check.
    Rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL areset_async got %b want %b",
               outs(), 5'b10000);
    end
`ifdef CONTROL_STATE_OUT_EN
    checks++;
    if (State !== 2'b00) begin
      errors++;
      $display("FAIL areset_state got %b want %b",
               State, 2'b00);
    end
`endif
    drive(1'b0, 1'b1, 1'b0);
    Rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL areset_no_resume got %b want %b",
               outs(), 5'b10000);
    end
  endtask

  task automatic test_free_run();
    logic [1:0] ms;
    logic [1:0] ms_nxt;
    logic [4:0] exp;
    logic       st;
    logic       m;
    logic       k;
    logic       prev_done;
    do_reset();
    ms        = 2'd0;
    prev_done = 1'b0;
    for (int n = 0; n < 128; n++) begin
      k  = n[1];
      m  = n[2];
      st = n[3];
      drive(st, m, k);
      exp    = 5'b00000;
      ms_nxt = ms;
      case (ms)
        2'd0: begin
          exp[4] = 1'b1;
          if (st) begin
            exp[3] = 1'b1;
            ms_nxt = 2'd1;
          end
        end
        2'd1: begin
          if (m) begin
            exp[2] = 1'b1;
            ms_nxt = 2'd2;
          end else begin
            exp[1] = 1'b1;
            ms_nxt = k ? 2'd3 : 2'd1;
          end
        end
        2'd2: begin
          exp[1] = 1'b1;
          ms_nxt = k ? 2'd3 : 2'd1;
        end
        default: begin
          exp[0] = 1'b1;
          ms_nxt = 2'd0;
        end
      endcase
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL free_cyc%0d got %b want %b",
                 n, outs(), exp);
      end
      checks++;
      if ((bus.Ad && bus.Sh) ||
          (bus.Load && !bus.Idle)) begin
        errors++;
        $display("FAIL free_excl%0d got %b want %s",
                 n, outs(), "Ad&Sh=0,Load->Idle");
      end
      if (prev_done) begin
        checks++;
        if (bus.Idle !== 1'b1) begin
          errors++;
          $display("FAIL free_done_idle%0d got %b want %b",
                   n, bus.Idle, 1'b1);
        end
      end
      prev_done = bus.Done;
      ms        = ms_nxt;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst_n  = 1'b0;
    bus.St = 1'b0;
    bus.M  = 1'b0;
    bus.K  = 1'b0;
    test_reset();
    test_start();
    test_all_zero();
    test_all_one();
    test_async_reset();
    test_free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
